// File: rtl/alu_flag_unit_if.sv
// Bus between the ALU subsystem / control unit and alu_flag_unit.
// master = producer/controller side, slave = the flag unit.
interface alu_flag_unit_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      R;
  logic             isZero;
  logic             ovfl;
  logic             flag_we;
  logic             trap_en;
  logic             branch_eval;
  logic [2:0]       cond;
  logic             exc_ack;
  logic [2:0]       flags;
  logic             branch_taken;
  logic             exc_req;
  logic             exc_overrun;
  logic [CNT_W-1:0] ovfl_count;

  modport master (
    output R, isZero, ovfl, flag_we, trap_en, branch_eval, cond, exc_ack,
    input  flags, branch_taken, exc_req, exc_overrun, ovfl_count
  );

  modport slave (
    input  R, isZero, ovfl, flag_we, trap_en, branch_eval, cond, exc_ack,
    output flags, branch_taken, exc_req, exc_overrun, ovfl_count
  );
endinterface

// File: rtl/alu_flag_unit.sv
// Condition-flag register {Z,N,V}, branch evaluator and 4-phase overflow-trap handshake.
// Optional ALU_OVFL_COUNT_EN adds a CNT_W-bit saturating overflow-event counter.
module alu_flag_unit #(
  parameter int CNT_W = 8
) (
  input  logic          CLK,
  input  logic          reset,
  alu_flag_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DRAIN = 2'b10
  } trap_state_e;

  trap_state_e state_r;
  trap_state_e state_next_s;
  logic [2:0]  flags_r;
  logic        branch_taken_r;
  logic        exc_overrun_r;
  logic        exc_req_s;
  logic [2:0]  incoming_flags_s;
  logic [2:0]  eval_flags_s;
  logic        branch_next_s;
  logic        trap_event_s;
  logic        drain_exit_s;

  function automatic logic cond_eval(input logic [2:0] code, input logic [2:0] f);
    logic taken;
    case (code)
      3'b000:  taken = 1'b1;
      3'b001:  taken = f[2];
      3'b010:  taken = ~f[2];
      3'b011:  taken = f[1] ^ f[0];
      3'b100:  taken = ~(f[1] ^ f[0]);
      3'b101:  taken = f[0];
      3'b110:  taken = ~f[0];
      3'b111:  taken = 1'b0;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Forward this cycle's ALU flags into the branch decision when they are being captured.
  always_comb begin
    incoming_flags_s = {bus.isZero, bus.R[15], bus.ovfl};
    trap_event_s     = bus.flag_we & bus.ovfl & bus.trap_en;
    if (bus.flag_we) begin
      eval_flags_s = incoming_flags_s;
    end else begin
      eval_flags_s = flags_r;
    end
    if (bus.branch_eval) begin
      branch_next_s = cond_eval(bus.cond, eval_flags_s);
    end else begin
      branch_next_s = 1'b0;
    end
  end

  // Architectural flag register and branch pulse.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      flags_r        <= 3'b000;
      branch_taken_r <= 1'b0;
    end else begin
      branch_taken_r <= branch_next_s;
      if (bus.flag_we) begin
        flags_r <= incoming_flags_s;
      end
    end
  end

  // Trap FSM state register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Trap FSM next-state logic; the controller owns the 4-phase ack discipline.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trap_event_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.exc_ack) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (!bus.exc_ack) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Trap FSM outputs decoded from the state register.
  always_comb begin
    exc_req_s    = (state_r == ST_REQ);
    drain_exit_s = (state_r == ST_DRAIN) & ~bus.exc_ack;
  end

  // Overrun is sticky until the handshake fully drains; a new event on that edge wins.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      exc_overrun_r <= 1'b0;
    end else if (trap_event_s && (state_r != ST_IDLE)) begin
      exc_overrun_r <= 1'b1;
    end else if (drain_exit_s) begin
      exc_overrun_r <= 1'b0;
    end
  end

`ifdef ALU_OVFL_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] ovfl_count_r;

  // Saturating count of every captured overflow, regardless of trap enable.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ovfl_count_r <= {CNT_W{1'b0}};
    end else if (bus.flag_we && bus.ovfl && (ovfl_count_r != CNT_MAX)) begin
      ovfl_count_r <= ovfl_count_r + CNT_W'(1);
    end
  end

  assign bus.ovfl_count = ovfl_count_r;
`else
  assign bus.ovfl_count = {CNT_W{1'b0}};
`endif

  assign bus.flags        = flags_r;
  assign bus.branch_taken = branch_taken_r;
  assign bus.exc_req      = exc_req_s;
  assign bus.exc_overrun  = exc_overrun_r;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed self-checking bench for alu_flag_unit (CNT_W=2 so counter saturation is reachable).
module tb_alu_flag_unit;
  localparam int TB_CNT_W = 2;
`ifdef ALU_OVFL_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic CLK;
  logic reset;
  int   checks;
  int   errors;

  alu_flag_unit_if #(.CNT_W(TB_CNT_W)) bus ();
  alu_flag_unit #(.CNT_W(TB_CNT_W)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [TB_CNT_W-1:0] cnt_exp(input int n);
    int sat;
    sat = (n > 3) ? 3 : n;
    return CNT_ON ? TB_CNT_W'(sat) : TB_CNT_W'(0);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.R = 16'h0000; bus.isZero = 1'b0; bus.ovfl = 1'b0; bus.flag_we = 1'b0;
    bus.trap_en = 1'b0; bus.branch_eval = 1'b0; bus.cond = 3'b000; bus.exc_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    checks += 5;
    if (bus.flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", bus.flags); end
    if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch got %b exp 0", bus.branch_taken); end
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.exc_req); end
    if (bus.exc_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.exc_overrun); end
    if (bus.ovfl_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.ovfl_count); end
    reset = 1'b1;
  endtask

  task automatic test_flag_capture();
    bus.R = 16'h8000; bus.isZero = 1'b0; bus.ovfl = 1'b1; bus.flag_we = 1'b1; bus.trap_en = 1'b0;
    tick();
    idle_inputs();
    checks += 3;
    if (bus.flags !== 3'b011) begin errors++; $display("FAIL capture_flags got %b exp 011", bus.flags); end
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL capture_no_req got %b exp 0", bus.exc_req); end
    if (bus.ovfl_count !== cnt_exp(1)) begin errors++; $display("FAIL capture_count got %0d exp %0d", bus.ovfl_count, cnt_exp(1)); end
    tick();
    checks += 2;
    if (bus.flags !== 3'b011) begin errors++; $display("FAIL capture_hold got %b exp 011", bus.flags); end
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL capture_no_req2 got %b exp 0", bus.exc_req); end
  endtask

  task automatic test_forwarding();
    bus.flag_we = 1'b1;
    tick();
    checks++;
    if (bus.flags !== 3'b000) begin errors++; $display("FAIL fwd_clear got %b exp 000", bus.flags); end
    bus.flag_we = 1'b1; bus.branch_eval = 1'b1; bus.cond = 3'b001; bus.isZero = 1'b1;
    tick();
    idle_inputs();
    checks += 2;
    if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL fwd_taken got %b exp 1", bus.branch_taken); end
    if (bus.flags !== 3'b100) begin errors++; $display("FAIL fwd_flags got %b exp 100", bus.flags); end
    tick();
    checks++;
    if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL fwd_pulse got %b exp 0", bus.branch_taken); end
  endtask

  task automatic test_conditions();
    logic [2:0] codes [8];
    logic       exps  [8];
    codes = '{3'b011, 3'b100, 3'b111, 3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
    exps  = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0};
    bus.R = 16'h8000; bus.ovfl = 1'b1; bus.flag_we = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.flags !== 3'b011) begin errors++; $display("FAIL cond_setup got %b exp 011", bus.flags); end
    for (int i = 0; i < 8; i++) begin
      bus.branch_eval = 1'b1; bus.cond = codes[i];
      tick();
      checks++;
      if (bus.branch_taken !== exps[i])
        begin errors++; $display("FAIL cond_%b got %b exp %b", codes[i], bus.branch_taken, exps[i]); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_trap_handshake();
    bus.flag_we = 1'b1; bus.ovfl = 1'b1; bus.trap_en = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.exc_req !== 1'b1) begin errors++; $display("FAIL trap_req got %b exp 1", bus.exc_req); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.exc_req !== 1'b1) begin errors++; $display("FAIL trap_hold%0d got %b exp 1", i, bus.exc_req); end
    end
    bus.exc_ack = 1'b1;
    tick();
    checks += 2;
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL trap_ack_drop got %b exp 0", bus.exc_req); end
    if (bus.exc_overrun !== 1'b0) begin errors++; $display("FAIL trap_no_overrun got %b exp 0", bus.exc_overrun); end
    bus.flag_we = 1'b1; bus.ovfl = 1'b1; bus.trap_en = 1'b1;
    tick();
    bus.flag_we = 1'b0; bus.ovfl = 1'b0; bus.trap_en = 1'b0;
    checks += 2;
    if (bus.exc_overrun !== 1'b1) begin errors++; $display("FAIL trap_overrun got %b exp 1", bus.exc_overrun); end
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL trap_drain_req got %b exp 0", bus.exc_req); end
    tick();
    checks++;
    if (bus.exc_overrun !== 1'b1) begin errors++; $display("FAIL trap_sticky got %b exp 1", bus.exc_overrun); end
    bus.exc_ack = 1'b0;
    tick();
    checks += 2;
    if (bus.exc_overrun !== 1'b0) begin errors++; $display("FAIL trap_clear got %b exp 0", bus.exc_overrun); end
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL trap_idle_req got %b exp 0", bus.exc_req); end
    tick();
    checks++;
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL trap_idle_stay got %b exp 0", bus.exc_req); end
  endtask

  task automatic test_async_reset();
    bus.flag_we = 1'b1; bus.ovfl = 1'b1; bus.trap_en = 1'b1; bus.R = 16'h8000;
    bus.branch_eval = 1'b1; bus.cond = 3'b000;
    tick();
    idle_inputs();
    checks += 3;
    if (bus.exc_req !== 1'b1) begin errors++; $display("FAIL arst_pre_req got %b exp 1", bus.exc_req); end
    if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL arst_pre_br got %b exp 1", bus.branch_taken); end
    if (bus.flags !== 3'b011) begin errors++; $display("FAIL arst_pre_flags got %b exp 011", bus.flags); end
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL arst_req got %b exp 0", bus.exc_req); end
    if (bus.flags !== 3'b000) begin errors++; $display("FAIL arst_flags got %b exp 000", bus.flags); end
    if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL arst_br got %b exp 0", bus.branch_taken); end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.exc_req !== 1'b0) begin errors++; $display("FAIL arst_idle got %b exp 0", bus.exc_req); end
    // A fresh trap must be accepted, proving the FSM restarted in IDLE.
    bus.flag_we = 1'b1; bus.ovfl = 1'b1; bus.trap_en = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.exc_req !== 1'b1) begin errors++; $display("FAIL arst_retrap got %b exp 1", bus.exc_req); end
    bus.exc_ack = 1'b1;
    tick();
    bus.exc_ack = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    checks++;
    if (bus.ovfl_count !== 2'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", bus.ovfl_count); end
    for (int i = 1; i <= 5; i++) begin
      bus.flag_we = 1'b1; bus.ovfl = 1'b1; bus.trap_en = 1'b0;
      tick();
      checks++;
      if (bus.ovfl_count !== cnt_exp(i))
        begin errors++; $display("FAIL sat_step%0d got %0d exp %0d", i, bus.ovfl_count, cnt_exp(i)); end
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.ovfl_count !== cnt_exp(5)) begin errors++; $display("FAIL sat_hold got %0d exp %0d", bus.ovfl_count, cnt_exp(5)); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_flag_capture();
    test_forwarding();
    test_conditions();
    test_trap_handshake();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
Downstream stage of the ALU subsystem. Consumes the unregistered ALU result, zero and overflow outputs, and holds the architectural condition flags (Z, N, V). It evaluates branch conditions for the control unit. It also raises an overflow trap toward the control unit using a 4-phase req/ack handshake. Sits between the ALU subsystem and the control FSM / PC-select logic.

Parameters:
CNT_W, 8, width of the saturating overflow-event counter (only present with ALU_OVFL_COUNT_EN)

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
R  input  16  ALU result (combinational, same cycle as isZero/ovfl)
isZero  input  1  ALU zero flag
ovfl  input  1  ALU signed-overflow flag
flag_we  input  1  capture flags from this cycle's ALU outputs
trap_en  input  1  overflow trap enable, sampled with flag_we
branch_eval  input  1  evaluate cond this cycle
cond  input  3  condition code
exc_ack  input  1  trap acknowledge from control unit
flags  output  3  {Z,N,V} flag register
branch_taken  output  1  registered branch decision, 1-cycle pulse
exc_req  output  1  overflow trap request
exc_overrun  output  1  sticky: trap-worthy overflow arrived while a trap was in flight
ovfl_count  output  CNT_W  saturating count of captured overflows

Behaviour:
- Reset (reset=0, asynchronous): flags=3'b000, branch_taken=0, exc_req=0, exc_overrun=0, ovfl_count=0, FSM=IDLE. Reset mid-handshake abandons the trap with no pending state.
- Flag capture: on CLK edge with flag_we=1: Z<=isZero, N<=R[15], V<=ovfl. When flag_we=0, flags hold.
- Branch evaluation: on CLK edge with branch_eval=1, branch_taken<=eval(cond). Otherwise branch_taken<=0. Latency is 1 cycle and output is a pulse.
- Flag forwarding: if flag_we and branch_eval are both 1 in the same cycle, eval uses the incoming {isZero,R[15],ovfl}, not the stored flags.
- Condition codes: 000 always; 001 EQ (Z); 010 NE (!Z); 011 LT (N^V); 100 GE (!(N^V)); 101 VS (V); 110 VC (!V); 111 never.
- Trap event: flag_we & ovfl & trap_en in a given cycle.
- Trap FSM states:
  - IDLE (exc_req=0): on trap event -> REQ.
  - REQ (exc_req=1): hold until exc_ack=1, then -> DRAIN.
  - DRAIN (exc_req=0): wait for exc_ack=0, then -> IDLE.
- A trap event in IDLE while exc_ack is still 1 still goes to REQ. The REQ state then exits immediately on the next edge (ack already high). The controller is responsible for the 4-phase discipline.
- Trap event in REQ or DRAIN: no new request; exc_overrun<=1.
- exc_overrun clears only on the DRAIN->IDLE transition or on reset. A trap event in the same cycle as DRAIN->IDLE sets exc_overrun (set wins) and does not start a new request.
- ovfl_count: +1 on every edge with flag_we&ovfl, independent of trap_en. Saturates at 2^CNT_W-1 (no wrap).

Optional Feature:
- Macro: ALU_OVFL_COUNT_EN.
- Defined: CNT_W-bit saturating counter is implemented as described above.
- Undefined: no counter register is generated and ovfl_count is tied to 0. All other behaviour is identical.

Test Plan:
- Reset release, then flag_we with R=16'h8000, isZero=0, ovfl=1 -> flags=3'b011 next cycle. exc_req stays 0 (trap_en=0). ovfl_count=1.
- Forwarding: stored flags=000; in one cycle flag_we=1, branch_eval=1, cond=001, isZero=1 -> branch_taken=1 on the next cycle, 0 on the cycle after.
- LT/GE: flags N=1, V=1; cond=011 -> branch_taken=0; cond=100 -> branch_taken=1; cond=111 -> 0; cond=000 -> 1.
- Trap handshake: trap event -> exc_req=1 next cycle and held 5 cycles with ack=0. ack=1 -> exc_req=0. Second trap event during DRAIN -> exc_overrun=1. ack=0 -> IDLE and exc_overrun=0.
- Saturation (CNT_W=2, macro defined): 5 consecutive flag_we&ovfl cycles -> ovfl_count reads 1,2,3,3,3. With macro undefined, ovfl_count stays 0.
- Async reset: assert reset=0 mid-REQ between clock edges -> exc_req, flags, and branch_taken all 0 immediately. The FSM is in IDLE after release.
